i2c_txn_sequencer: RTL and testbench

Transaction front-end sitting directly upstream of the I2C controller. Accepts register-level read/write requests over a valid/ready interface and buffers them in a small FIFO. Launches them one at a time on the controller's `en`/`busy` handshake, then returns read data (or a timeout flag) on a valid/ready response port. It isolates system logic from the controller's free-running, slower serial timing.

---
 rtl/i2c_pkg.sv | 17 +
 rtl/i2c_txn_sequencer_if.sv | 36 +++
 rtl/i2c_req_fifo.sv | 38 +++
 rtl/i2c_txn_sequencer.sv | 94 +++++++++
 tb/tb_i2c_txn_sequencer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared widths, FSM encoding and request layout for the I2C transaction sequencer
package i2c_pkg;
  localparam int ADDR_W = 7;
  localparam int REG_W = 8;
  localparam int DATA_W = 16;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT_HI = 3'd1;
  localparam logic [2:0] S_WAIT_LO = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
  localparam logic [2:0] S_COOL = 3'd4;
  typedef struct packed {
    logic rw;
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0] regn;
    logic [DATA_W-1:0] data;
  } req_t;
endpackage

// File: rtl/i2c_txn_sequencer_if.sv
// i2c_txn_sequencer_if: request/response handshakes plus controller fields of the sequencer
//   slave  : the sequencer side (takes requests, drives responses and the controller)
//   master : the system/controller side
interface i2c_txn_sequencer_if #(parameter int FIFO_DEPTH = 4);
  import i2c_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic req_valid;
  logic req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [REG_W-1:0] req_reg;
  logic req_rw;
  logic [DATA_W-1:0] req_data;
  logic rsp_valid;
  logic rsp_ready;
  logic rsp_rw;
  logic [DATA_W-1:0] rsp_data;
  logic rsp_timeout;
  logic [CW-1:0] fifo_count;
  logic ctl_en;
  logic [ADDR_W-1:0] ctl_peripheral_address;
  logic [REG_W-1:0] ctl_target_register;
  logic ctl_rw;
  logic [DATA_W-1:0] ctl_din;
  logic [DATA_W-1:0] ctl_dout;
  logic ctl_busy;
  modport slave (
    input req_valid, req_addr, req_reg, req_rw, req_data, rsp_ready, ctl_dout, ctl_busy,
    output req_ready, rsp_valid, rsp_rw, rsp_data, rsp_timeout, fifo_count,
    output ctl_en, ctl_peripheral_address, ctl_target_register, ctl_rw, ctl_din
  );
  modport master (
    output req_valid, req_addr, req_reg, req_rw, req_data, rsp_ready, ctl_dout, ctl_busy,
    input req_ready, rsp_valid, rsp_rw, rsp_data, rsp_timeout, fifo_count,
    input ctl_en, ctl_peripheral_address, ctl_target_register, ctl_rw, ctl_din
  );
endinterface

// File: rtl/i2c_req_fifo.sv
// i2c_req_fifo: 32-bit request FIFO with push/pop/count
//   push/din : write an entry; pop : discard head; dout : head entry; count : occupancy
module i2c_req_fifo import i2c_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  req_t din,
  output req_t dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  req_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= din;
  assign dout = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: queues register requests and runs them one at a time on the controller en/busy handshake
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : request and response valid/ready ports, FIFO occupancy, controller fields
module i2c_txn_sequencer import i2c_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int BUSY_TIMEOUT = 65535,
  parameter int COOLDOWN = 16
) (
  input logic clk,
  input logic rst_n,
  i2c_txn_sequencer_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2((BUSY_TIMEOUT > COOLDOWN ? BUSY_TIMEOUT : COOLDOWN) + 1);
  logic [2:0] state_q, state_d;
  logic [1:0] passes_q, passes_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic ctl_en_q, ctl_en_d;
  req_t hold_q, hold_d, head, din;
  logic rsp_valid_q, rsp_valid_d, rsp_rw_q, rsp_rw_d, rsp_timeout_q, rsp_timeout_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic busy_m_q, busy_s_q, busy_p_q;
  logic [CW-1:0] count;
  logic push, pop, rise, fall, waiting, expired, finish, abort;
  assign din = {bus.req_rw, bus.req_addr, bus.req_reg, bus.req_data};
  assign bus.req_ready = count != CW'(FIFO_DEPTH);
  assign push = bus.req_valid & bus.req_ready;
  assign pop = state_q == S_IDLE && count != '0;
  i2c_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din), .dout(head), .count(count)
  );
  // edges only from the synchronized copy; ctl_busy lives on the controller's derived clock
  assign rise = busy_s_q & ~busy_p_q;
  assign fall = ~busy_s_q & busy_p_q;
  assign waiting = state_q == S_WAIT_HI || state_q == S_WAIT_LO;
  assign expired = waiting && tmr_q == TW'(BUSY_TIMEOUT - 1);
  assign finish = state_q == S_WAIT_LO && fall && passes_q == 2'd1;
  // a real edge in the same cycle as expiry wins over the abort
  assign abort = expired && !(state_q == S_WAIT_HI ? rise : fall);
  always_comb begin
    case (state_q)
      S_IDLE:    state_d = pop ? S_WAIT_HI : S_IDLE;
      S_WAIT_HI: state_d = rise ? S_WAIT_LO : abort ? S_RESP : S_WAIT_HI;
      S_WAIT_LO: state_d = finish || abort ? S_RESP : fall ? S_WAIT_HI : S_WAIT_LO;
      S_RESP:    state_d = bus.rsp_ready ? S_COOL : S_RESP;
      S_COOL:    state_d = tmr_q == TW'(COOLDOWN - 1) ? S_IDLE : S_COOL;
      default:   state_d = S_IDLE;
    endcase
    hold_d = pop ? head : hold_q;
    // a read needs an address pass and a data pass on the controller
    passes_d = pop ? (head.rw ? 2'd2 : 2'd1) : state_q == S_WAIT_LO && fall ? passes_q - 2'd1 : passes_q;
    tmr_d = state_d != state_q ? '0 : tmr_q + TW'(1);
    // en follows the wait states one cycle late, and drops on the very edge that leaves them
    ctl_en_d = waiting && (state_d == S_WAIT_HI || state_d == S_WAIT_LO);
    rsp_valid_d = finish || abort ? 1'b1 : state_q == S_RESP && bus.rsp_ready ? 1'b0 : rsp_valid_q;
    rsp_rw_d = finish || abort ? hold_q.rw : rsp_rw_q;
    rsp_data_d = finish ? (hold_q.rw ? bus.ctl_dout : '0) : abort ? '0 : rsp_data_q;
    rsp_timeout_d = finish || abort ? abort : rsp_timeout_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      passes_q <= '0;
      tmr_q <= '0;
      hold_q <= '0;
      ctl_en_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rw_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_timeout_q <= 1'b0;
      {busy_p_q, busy_s_q, busy_m_q} <= '0;
    end else begin
      state_q <= state_d;
      passes_q <= passes_d;
      tmr_q <= tmr_d;
      hold_q <= hold_d;
      ctl_en_q <= ctl_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rw_q <= rsp_rw_d;
      rsp_data_q <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      {busy_p_q, busy_s_q, busy_m_q} <= {busy_s_q, busy_m_q, bus.ctl_busy};
    end
  assign bus.fifo_count = count;
  assign bus.ctl_en = ctl_en_q;
  assign bus.ctl_peripheral_address = hold_q.addr;
  assign bus.ctl_target_register = hold_q.regn;
  assign bus.ctl_rw = hold_q.rw;
  assign bus.ctl_din = hold_q.data;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rw = rsp_rw_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: directed checks of the sequencer against a simple busy-pulse controller model
module tb_i2c_txn_sequencer;
  localparam int DEPTH = 4;
  logic clk, rst_n;
  int n_tests = 0, n_fail = 0, pulses = 0;
  logic dead = 1'b0;
  logic [15:0] dout_val = 16'h1234;
  i2c_txn_sequencer_if #(.FIFO_DEPTH(DEPTH)) bus ();
  i2c_txn_sequencer #(.FIFO_DEPTH(DEPTH), .BUSY_TIMEOUT(100), .COOLDOWN(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.ctl_busy = 1'b0;
    bus.ctl_dout = '0;
    forever begin
      @(negedge clk);
      if (bus.ctl_en && !dead) begin
        pulses++;
        repeat (3) @(negedge clk);
        bus.ctl_busy = 1'b1;
        bus.ctl_dout = 16'hBAD0;
        repeat (8) @(negedge clk);
        bus.ctl_dout = dout_val ^ {8'h00, bus.ctl_target_register};
        bus.ctl_busy = 1'b0;
        repeat (6) @(negedge clk);
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic push_req(input logic [6:0] a, input logic [7:0] r, input logic rw, input logic [15:0] d);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_addr = a;
    bus.req_reg = r;
    bus.req_rw = rw;
    bus.req_data = d;
    while (!bus.req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("push_accepted", 32'(n < 500), 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask
  task automatic wait_rsp(input int limit);
    int n = 0;
    while (!bus.rsp_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("rsp_seen", 32'(bus.rsp_valid), 1);
  endtask
  task automatic wait_en(input int limit);
    int n = 0;
    while (!bus.ctl_en && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("en_seen", 32'(bus.ctl_en), 1);
  endtask
  task automatic accept();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask
  initial begin
    int p0, n;
    logic saw_rsp, saw_en;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.req_reg = '0;
    bus.req_rw = 1'b0;
    bus.req_data = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_rw", 32'(bus.rsp_rw), 0);
    check("rst_rsp_data", 32'(bus.rsp_data), 0);
    check("rst_rsp_timeout", 32'(bus.rsp_timeout), 0);
    check("rst_fifo_count", 32'(bus.fifo_count), 0);
    check("rst_ctl_en", 32'(bus.ctl_en), 0);
    check("rst_ctl_fields", {bus.ctl_rw, bus.ctl_peripheral_address, bus.ctl_target_register, bus.ctl_din}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    p0 = pulses;
    push_req(7'h48, 8'h01, 1'b0, 16'hA5C3);
    check("launch_n_en", 32'(bus.ctl_en), 0);
    check("launch_n_count", 32'(bus.fifo_count), 1);
    @(negedge clk);
    check("launch_n1_en", 32'(bus.ctl_en), 0);
    @(negedge clk);
    check("launch_n2_en", 32'(bus.ctl_en), 1);
    check("wr_ctl_din", 32'(bus.ctl_din), 'hA5C3);
    check("wr_ctl_addr", 32'(bus.ctl_peripheral_address), 'h48);
    check("wr_ctl_reg", 32'(bus.ctl_target_register), 'h01);
    check("wr_ctl_rw", 32'(bus.ctl_rw), 0);
    wait_rsp(200);
    check("wr_rsp_rw", 32'(bus.rsp_rw), 0);
    check("wr_rsp_data", 32'(bus.rsp_data), 0);
    check("wr_rsp_timeout", 32'(bus.rsp_timeout), 0);
    check("wr_pulses", 32'(pulses - p0), 1);
    check("wr_din_held", 32'(bus.ctl_din), 'hA5C3);
    accept();
    repeat (20) @(negedge clk);
    p0 = pulses;
    push_req(7'h48, 8'h00, 1'b1, 16'h0000);
    wait_en(10);
    check("rd_ctl_rw", 32'(bus.ctl_rw), 1);
    wait_rsp(200);
    check("rd_rsp_data", 32'(bus.rsp_data), 'h1234);
    check("rd_rsp_timeout", 32'(bus.rsp_timeout), 0);
    check("rd_rsp_rw", 32'(bus.rsp_rw), 1);
    check("rd_pulses", 32'(pulses - p0), 2);
    accept();
    repeat (20) @(negedge clk);
    for (int i = 0; i < 5; i++) push_req(7'h50, 8'(16 + i), 1'b1, 16'h0000);
    check("full_count", 32'(bus.fifo_count), DEPTH);
    check("full_ready", 32'(bus.req_ready), 0);
    fork
      push_req(7'h50, 8'h15, 1'b1, 16'h0000);
    join_none
    repeat (5) @(negedge clk);
    check("full_hold_count", 32'(bus.fifo_count), DEPTH);
    check("full_hold_ready", 32'(bus.req_ready), 0);
    wait_rsp(200);
    repeat (5) @(negedge clk);
    check("stall_valid", 32'(bus.rsp_valid), 1);
    check("stall_data", 32'(bus.rsp_data), 'h1224);
    for (int i = 0; i < 6; i++) begin
      wait_rsp(400);
      check("fifo_rsp_data", 32'(bus.rsp_data), 32'(16'h1234 ^ (16'h0010 + 16'(i))));
      check("fifo_rsp_rw", 32'(bus.rsp_rw), 1);
      accept();
      if (i == 0) begin
        n = 0;
        while (bus.req_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        check("refill_count", 32'(bus.fifo_count), DEPTH);
      end
    end
    repeat (20) @(negedge clk);
    dead = 1'b1;
    push_req(7'h22, 8'h05, 1'b0, 16'hBEEF);
    push_req(7'h23, 8'h06, 1'b0, 16'h0F0F);
    wait_en(10);
    n = 0;
    while (bus.ctl_en && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("timeout_en_cycles", 32'(n), 99);
    wait_rsp(10);
    check("timeout_flag", 32'(bus.rsp_timeout), 1);
    check("timeout_data", 32'(bus.rsp_data), 0);
    check("timeout_rw", 32'(bus.rsp_rw), 0);
    check("timeout_addr_held", 32'(bus.ctl_peripheral_address), 'h22);
    accept();
    n = 0;
    while (!bus.ctl_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cooldown_relaunch", 32'(n), 18);
    check("next_addr", 32'(bus.ctl_peripheral_address), 'h23);
    dead = 1'b0;
    wait_rsp(200);
    check("recover_timeout", 32'(bus.rsp_timeout), 0);
    accept();
    repeat (20) @(negedge clk);
    push_req(7'h48, 8'h33, 1'b1, 16'h0000);
    push_req(7'h48, 8'h34, 1'b0, 16'h5555);
    n = 0;
    while (!bus.ctl_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_busy_seen", 32'(bus.ctl_busy), 1);
    repeat (4) @(negedge clk);
    check("rst_pre_count", 32'(bus.fifo_count), 1);
    check("rst_pre_en", 32'(bus.ctl_en), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_en", 32'(bus.ctl_en), 0);
    check("rst_async_count", 32'(bus.fifo_count), 0);
    check("rst_async_valid", 32'(bus.rsp_valid), 0);
    check("rst_async_rw", 32'(bus.ctl_rw), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    saw_rsp = 1'b0;
    saw_en = 1'b0;
    repeat (60) begin
      @(negedge clk);
      saw_rsp |= bus.rsp_valid;
      saw_en |= bus.ctl_en;
    end
    check("post_rst_no_rsp", 32'(saw_rsp), 0);
    check("post_rst_no_en", 32'(saw_en), 0);
    check("post_rst_count", 32'(bus.fifo_count), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
